// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Only the fields needed after acceptance are kept.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } lsu_req_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane select with sign/zero extension for loads, and byte/half merge for
// read-modify-write stores, both keyed by the same lane and funct3.
module load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    ld_data = word;
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'h0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'h0, half_sel};
      default: ld_data = word;
    endcase

    st_word = word;
    case (funct3[1:0])
      2'b00: st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) st_word[31:16] = wdata;
        else         st_word[15:0]  = wdata;
      end
      default: st_word = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed BRAM; sub-word stores are done
// as read-modify-write since the BRAM only commits full words.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter int          ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] mem_r_addr,
  output logic                 mem_r_enb,
  input  logic [31:0]          mem_r_dat,
  output logic [ADDR_BITS-1:0] mem_w_addr,
  output logic [31:0]          mem_w_dat,
  output logic [3:0]           mem_w_enb
);

  localparam logic [32:0] WIN_END = {1'b0, DMEM_BASE} + (33'd1 << (ADDR_BITS + 2));

  lsu_state_e          state;
  lsu_req_t            rq;
  logic [ADDR_BITS-1:0] word_addr;
  logic                out_win, misalign, acc_err;
  logic [31:0]         ld_data, st_word;

  assign req_ready = (state == ST_IDLE) && !rst;

  // The window base is word aligned, so only the word-index bits need subtracting.
  assign word_addr = req_addr[ADDR_BITS+1:2] - DMEM_BASE[ADDR_BITS+1:2];
  assign out_win   = (req_addr < DMEM_BASE) || ({1'b0, req_addr} >= WIN_END);

  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign acc_err = out_win || misalign || !f3_legal(req_we, req_funct3);

  load_align u_align (
    .word    (mem_r_dat),
    .lane    (rq.lane),
    .funct3  (rq.funct3),
    .wdata   (rq.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rq         <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_r_enb  <= 1'b0;
      mem_r_addr <= '0;
      mem_w_enb  <= 4'b0000;
      mem_w_addr <= '0;
      mem_w_dat  <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_r_enb  <= 1'b0;
      mem_w_enb  <= 4'b0000;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rq <= '{we: req_we, funct3: req_funct3, lane: req_addr[1:0],
                    wdata: req_wdata[15:0]};
            if (acc_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_funct3 == F3_W) begin
              state      <= ST_WRITE;
              mem_w_enb  <= 4'b1111;
              mem_w_addr <= word_addr;
              mem_w_dat  <= req_wdata;
            end else begin
              state      <= ST_READ;
              mem_r_enb  <= 1'b1;
              mem_r_addr <= word_addr;
              mem_w_addr <= word_addr;
            end
          end
        end
        ST_READ: begin
          if (rq.we) begin
            state     <= ST_WRITE;
            mem_w_enb <= 4'b1111;
            mem_w_dat <= st_word;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_data;
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and random checks of dmem_lsu against a behavioural BRAM and a
// reference memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_r_addr;
  logic        mem_r_enb;
  logic [31:0] mem_r_dat;
  logic [9:0]  mem_w_addr;
  logic [31:0] mem_w_dat;
  logic [3:0]  mem_w_enb;

  int checks = 0;
  int errors = 0;

  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic [9:0]  last_waddr = '0;
  logic [31:0] last_wdat = '0;

  logic [31:0] bram [0:1023];
  logic [31:0] refm [0:1023];

  always #5 clk = ~clk;

  dmem_lsu #(.DMEM_BASE(32'h0000_1000), .ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb), .mem_r_dat(mem_r_dat),
    .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb)
  );

  // BRAM: asynchronous read, full-word write, cleared by reset.
  assign mem_r_dat = bram[mem_r_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) bram[i] <= '0;
    end else if (mem_w_enb == 4'b1111) begin
      bram[mem_w_addr] <= mem_w_dat;
    end
  end

  // Per-cycle bus monitor: read/write exclusion and legal write masks.
  always @(negedge clk) begin
    checks++;
    if ((mem_r_enb && mem_w_enb != 4'b0000) ||
        (mem_w_enb != 4'b0000 && mem_w_enb != 4'b1111)) begin
      errors++;
      $display("FAIL bus_excl: r_enb=%b w_enb=%b required r_enb&w_enb exclusive, w_enb 0000/1111",
               mem_r_enb, mem_w_enb);
    end
    if (mem_r_enb) rd_pulses++;
    if (mem_w_enb == 4'b1111) begin
      wr_pulses++;
      last_waddr = mem_w_addr;
      last_wdat  = mem_w_dat;
    end
  end

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int          idx, sh;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    logic        bad;
    rd  = '0;
    bad = (a < 32'h1000) || (a > 32'h1FFF);
    case (f3)
      3'd0, 3'd4: ;
      3'd1, 3'd5: if (a % 2 != 0) bad = 1'b1;
      3'd2:       if (a % 4 != 0) bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    if (we && f3 > 3'd2) bad = 1'b1;
    er = bad;
    if (bad) return;
    idx = int'((a - 32'h1000) / 4);
    w   = refm[idx];
    sh  = int'(a % 4) * 8;
    b   = 8'(w >> sh);
    h   = 16'(w >> sh);
    if (!we) begin
      case (f3)
        3'd0:    rd = {{24{b[7]}}, b};
        3'd4:    rd = {24'h0, b};
        3'd1:    rd = {{16{h[15]}}, h};
        3'd5:    rd = {16'h0, h};
        default: rd = w;
      endcase
    end else begin
      case (f3)
        3'd0:    refm[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        3'd1:    refm[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        default: refm[idx] = wd;
      endcase
    end
  endfunction

  // Drives one request and waits (bounded) for its response pulse.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic rdy, output logic [31:0] rd,
                       output logic er, output int lat, output logic got,
                       output int nrd, output int nwr);
    int r0, w0;
    @(negedge clk);
    rdy = req_ready;
    r0 = rd_pulses; w0 = wr_pulses;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0; rd = 'x; er = 'x;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; lat = i; rd = resp_rdata; er = resp_err; end
    end
    #1;
    nrd = rd_pulses - r0;
    nwr = wr_pulses - w0;
  endtask

  logic        t_rdy, t_er, t_got;
  logic [31:0] t_rd;
  int          t_lat, t_nrd, t_nwr;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, mem_r_enb, mem_w_enb, req_ready} !== 8'b0 ||
        resp_rdata !== 32'h0 || mem_r_addr !== 10'h0 || mem_w_addr !== 10'h0 ||
        mem_w_dat !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b err=%b rdata=%h renb=%b wenb=%b rdy=%b raddr=%h waddr=%h wdat=%h required all 0",
               resp_valid, resp_err, resp_rdata, mem_r_enb, mem_w_enb, req_ready,
               mem_r_addr, mem_w_addr, mem_w_dat);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_sw_lw();
    issue(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_rd !== 32'h0 || t_lat != 2 || t_nwr != 1 || t_nrd != 0 ||
        last_waddr !== 10'd1 || last_wdat !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_word: got=%b err=%b rdata=%h lat=%0d nwr=%0d nrd=%0d waddr=%0d wdat=%h required 1 0 0 2 1 0 1 deadbeef",
               t_got, t_er, t_rd, t_lat, t_nwr, t_nrd, last_waddr, last_wdat);
    end
    issue(1'b0, 3'b010, 32'h1004, 32'h0, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_rd !== 32'hDEADBEEF || t_lat != 2 || t_nwr != 0 || t_nrd != 1) begin
      errors++;
      $display("FAIL lw_word: got=%b err=%b rdata=%h lat=%0d nwr=%0d nrd=%0d required 1 0 deadbeef 2 0 1",
               t_got, t_er, t_rd, t_lat, t_nwr, t_nrd);
    end
  endtask

  task automatic test_subword();
    logic [2:0]  f3s [3]  = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adrs [3] = '{32'h1007, 32'h1007, 32'h1004};
    logic [31:0] exps [3] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF};
    issue(1'b1, 3'b000, 32'h1006, 32'h00000012, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_lat != 3 || t_nrd != 1 || t_nwr != 1 ||
        last_waddr !== 10'd1 || last_wdat !== 32'hDE12BEEF) begin
      errors++;
      $display("FAIL sb_rmw: got=%b err=%b lat=%0d nrd=%0d nwr=%0d waddr=%0d wdat=%h required 1 0 3 1 1 1 de12beef",
               t_got, t_er, t_lat, t_nrd, t_nwr, last_waddr, last_wdat);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
      checks++;
      if (!t_got || t_er !== 1'b0 || t_rd !== exps[i] || t_lat != 2) begin
        errors++;
        $display("FAIL subword_load%0d: got=%b err=%b rdata=%h lat=%0d required 1 0 %h 2",
                 i, t_got, t_er, t_rd, t_lat, exps[i]);
      end
    end
  endtask

  task automatic test_sh();
    issue(1'b1, 3'b001, 32'h1002, 32'hAAAA7FFF, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_lat != 3 || t_nwr != 1 ||
        last_waddr !== 10'd0 || last_wdat !== 32'h7FFF0000) begin
      errors++;
      $display("FAIL sh_rmw: got=%b err=%b lat=%0d nwr=%0d waddr=%0d wdat=%h required 1 0 3 1 0 7fff0000",
               t_got, t_er, t_lat, t_nwr, last_waddr, last_wdat);
    end
    issue(1'b0, 3'b101, 32'h1002, 32'h0, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_rd !== 32'h00007FFF) begin
      errors++;
      $display("FAIL lhu_upper: got=%b err=%b rdata=%h required 1 0 00007fff", t_got, t_er, t_rd);
    end
  endtask

  task automatic test_errors();
    logic        wes [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5]  = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010};
    logic [31:0] adrs [5] = '{32'h1002, 32'h1001, 32'h1000, 32'h0FFC, 32'h2000};
    for (int i = 0; i < 5; i++) begin
      issue(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
      checks++;
      if (!t_got || t_er !== 1'b1 || t_rd !== 32'h0 || t_lat != 1 || t_nrd != 0 || t_nwr != 0) begin
        errors++;
        $display("FAIL error_case%0d: got=%b err=%b rdata=%h lat=%0d nrd=%0d nwr=%0d required 1 1 0 1 0 0",
                 i, t_got, t_er, t_rd, t_lat, t_nrd, t_nwr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    issue(1'b1, 3'b010, 32'h1008, 32'hCAFEF00D, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    w0 = wr_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1008; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_r_enb !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_read: r_enb=%b required 1", mem_r_enb);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_w_enb !== 4'b0000 || mem_r_enb !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: w_enb=%b r_enb=%b vld=%b rdy=%b required 0000 0 0 0",
               mem_w_enb, mem_r_enb, resp_valid, req_ready);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (req_ready !== 1'b1 || wr_pulses != w0) begin
      errors++;
      $display("FAIL rstmid_release: rdy=%b writes=%0d required 1 0", req_ready, wr_pulses - w0);
    end
    issue(1'b0, 3'b010, 32'h1008, 32'h0, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
    checks++;
    if (!t_got || t_er !== 1'b0 || t_rd !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_followup: got=%b err=%b rdata=%h required 1 0 0", t_got, t_er, t_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        we, e_er;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd;
    int          r, k, e_lat;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) refm[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (r == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        k  = int'($urandom_range(0, 4));
        f3 = (k < 3) ? 3'(k) : ((k == 3) ? 3'b100 : 3'b101);
      end
      a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      if (r == 1 || f3[1:0] == 2'b00) a = a + 32'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) a = a + 32'($urandom_range(0, 1)) * 2;
      if (r == 2) a = $urandom_range(0, 1) ? 32'h0000_0FFC : 32'h0000_2000 + (a & 32'h3C);
      model(we, f3, a, wd, e_rd, e_er);
      e_lat = e_er ? 1 : ((we && f3 != 3'b010) ? 3 : 2);
      issue(we, f3, a, wd, t_rdy, t_rd, t_er, t_lat, t_got, t_nrd, t_nwr);
      checks++;
      if (t_rdy !== 1'b1 || !t_got || t_er !== e_er || t_rd !== e_rd || t_lat != e_lat) begin
        errors++;
        $display("FAIL rand%0d we=%b f3=%b a=%h: rdy=%b got=%b err=%b rdata=%h lat=%0d required 1 1 %b %h %0d",
                 n, we, f3, a, t_rdy, t_got, t_er, t_rd, t_lat, e_er, e_rd, e_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_subword();
    test_sh();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
